// File: rtl/vwb_macc_sched.sv
// Chunk scheduler for the vector-wise weight/bias MACC layer: pops input chunks,
// steps the weight/bias RAM address and writes results after the RAM latency.
module vwb_macc_sched #(
    parameter int InVecLength = 32,
    parameter int WorkingRegs = 8,
    parameter int RamLatency  = 1,
    parameter int OutCredits  = 4,
    localparam int NumChunks  = InVecLength / WorkingRegs,
    localparam int AW         = (NumChunks > 1) ? $clog2(NumChunks) : 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          layer_en,
    input  logic          in_fifo_empty,
    output logic          in_fifo_rd,
    output logic [AW-1:0] wb_addr,
    input  logic          out_credit_return,
    output logic          out_fifo_wr,
    output logic          out_chunk_last,
    output logic          vec_done,
    output logic [15:0]   vec_count,
    output logic          busy,
    output logic          err_credit
);

    localparam int CW = $clog2(OutCredits + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [AW-1:0]         chunk_idx_r;
    logic [AW-1:0]         wb_addr_r;
    logic [CW-1:0]         credits_r;
    logic [RamLatency-1:0] dl_vld_r;
    logic [RamLatency-1:0] dl_last_r;
    logic [RamLatency:0]   vld_chain_s;
    logic [RamLatency:0]   last_chain_s;
    logic [15:0]           vec_count_r;
    logic                  err_r;
    logic                  issue_s;
    logic                  is_last_s;
    logic                  dl_busy_s;

    assign is_last_s    = (chunk_idx_r == AW'(NumChunks - 1));
    // Stage 0 of each chain is the issue happening this cycle.
    assign vld_chain_s  = {dl_vld_r, issue_s};
    assign last_chain_s = {dl_last_r, issue_s & is_last_s};
    assign dl_busy_s    = (dl_vld_r != {RamLatency{1'b0}});

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a vector is never abandoned once started.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (issue_s) state_nxt_s = RUN;
                else         state_nxt_s = IDLE;
            end
            RUN: begin
                if (issue_s && is_last_s && !layer_en) state_nxt_s = DRAIN;
                else                                   state_nxt_s = RUN;
            end
            DRAIN: begin
                if (!dl_busy_s) state_nxt_s = IDLE;
                else            state_nxt_s = DRAIN;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Issue decision; held low while reset is asserted so the pop is quiet too.
    always_comb begin
        issue_s = 1'b0;
        if (!rst_in && !in_fifo_empty && (credits_r != {CW{1'b0}})) begin
            case (state_r)
                RUN:     issue_s = 1'b1;
                IDLE:    issue_s = layer_en;
                DRAIN:   issue_s = 1'b0;
                default: issue_s = 1'b0;
            endcase
        end else begin
            issue_s = 1'b0;
        end
    end

    // Chunk index, RAM address and latency-matched {valid,last} delay line.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            chunk_idx_r <= {AW{1'b0}};
            wb_addr_r   <= {AW{1'b0}};
            dl_vld_r    <= {RamLatency{1'b0}};
            dl_last_r   <= {RamLatency{1'b0}};
        end else begin
            dl_vld_r  <= vld_chain_s[RamLatency-1:0];
            dl_last_r <= last_chain_s[RamLatency-1:0];
            if (issue_s) begin
                wb_addr_r   <= chunk_idx_r;
                chunk_idx_r <= is_last_s ? {AW{1'b0}} : chunk_idx_r + AW'(1);
            end
        end
    end

    // Credit counter mirroring output FIFO space, with sticky overflow flag.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            credits_r <= CW'(OutCredits);
            err_r     <= 1'b0;
        end else if (issue_s && !out_credit_return) begin
            credits_r <= credits_r - CW'(1);
        end else if (!issue_s && out_credit_return) begin
            if (credits_r == CW'(OutCredits)) err_r <= 1'b1;
            else                              credits_r <= credits_r + CW'(1);
        end
    end

    // Completed-vector counter, stepped at the edge that raises the last write.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vec_count_r <= 16'd0;
        end else if (vld_chain_s[RamLatency-1] && last_chain_s[RamLatency-1]) begin
            vec_count_r <= vec_count_r + 16'd1;
        end
    end

    assign in_fifo_rd     = issue_s;
    assign wb_addr        = wb_addr_r;
    assign out_fifo_wr    = dl_vld_r[RamLatency-1];
    assign out_chunk_last = dl_last_r[RamLatency-1];
    assign vec_done       = dl_vld_r[RamLatency-1] & dl_last_r[RamLatency-1];
    assign vec_count      = vec_count_r;
    assign busy           = (state_r != IDLE) || dl_busy_s;
    assign err_credit     = err_r;

endmodule

// File: tb/tb_vwb_macc_sched.sv
// Scoreboard bench for vwb_macc_sched: a vector-level model predicts pops and
// queues expected writes; an independent monitor checks every write.
module tb_vwb_macc_sched;

    localparam int RL = 1;
    localparam int NC = 4;
    localparam int OC = 4;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       layer_en = 1'b0;
    logic       in_fifo_empty = 1'b1;
    logic       in_fifo_rd;
    logic [1:0] wb_addr;
    logic       out_credit_return = 1'b0;
    logic       out_fifo_wr;
    logic       out_chunk_last;
    logic       vec_done;
    logic [15:0] vec_count;
    logic       busy;
    logic       err_credit;

    vwb_macc_sched dut (
        .clk_in(clk_in), .rst_in(rst_in), .layer_en(layer_en),
        .in_fifo_empty(in_fifo_empty), .in_fifo_rd(in_fifo_rd), .wb_addr(wb_addr),
        .out_credit_return(out_credit_return), .out_fifo_wr(out_fifo_wr),
        .out_chunk_last(out_chunk_last), .vec_done(vec_done), .vec_count(vec_count),
        .busy(busy), .err_credit(err_credit)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { int due; bit last; } exp_t;
    exp_t sb[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    // reference model state
    int avail, pos, m_cred, m_addr, m_drain_end, last_issue, exp_vec;
    bit m_run, m_err;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        avail = 0; pos = 0; m_cred = OC; m_addr = 0; m_drain_end = 0;
        last_issue = -100; exp_vec = 0; m_run = 0; m_err = 0;
    endtask

    // monitor: every write must match the next expected entry at its due cycle
    always @(negedge clk_in) begin
        if (!rst_in) begin
            bit exp_done;
            exp_t e;
            exp_done = 1'b0;
            if (out_fifo_wr) begin
                if (sb.size() == 0) begin
                    chk("unexpected_wr", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("wr_cycle", cyc, e.due);
                    chk("wr_last", out_chunk_last, e.last);
                    if (e.last) begin
                        exp_vec++;
                        exp_done = 1'b1;
                    end
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                chk("missing_wr", 0, 1);
                void'(sb.pop_front());
            end
            chk("vec_done", vec_done, exp_done);
            chk("vec_count", vec_count, exp_vec);
        end
    end

    task automatic step(input bit le, input bit ret, input int push);
        bit pred, last, exp_busy;
        @(negedge clk_in);
        exp_busy = m_run || (cyc < m_drain_end) || (last_issue >= cyc - RL);
        chk("wb_addr", wb_addr, m_addr);
        chk("err_credit", err_credit, m_err);
        chk("busy", busy, exp_busy);
        avail += push;
        layer_en = le;
        out_credit_return = ret;
        in_fifo_empty = (avail == 0);
        #1;
        pred = (avail > 0) && (m_cred > 0) && (m_run || (!(cyc < m_drain_end) && le));
        chk("in_fifo_rd", in_fifo_rd, pred);
        if (pred) begin
            last = (pos == NC - 1);
            sb.push_back('{cyc + RL, last});
            m_addr = pos;
            pos = last ? 0 : pos + 1;
            avail--;
            last_issue = cyc;
            if (last) begin
                m_run = le;
                if (!le) m_drain_end = cyc + RL + 2;
            end else begin
                m_run = 1'b1;
            end
        end
        if (pred && !ret) m_cred--;
        else if (!pred && ret) begin
            if (m_cred == OC) m_err = 1'b1;
            else m_cred++;
        end
    endtask

    task automatic refill();
        for (int i = 0; i < OC + 2; i++) step(1'b0, (m_cred < OC), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd"}, in_fifo_rd, 0);
        chk({tag, "_wr"}, out_fifo_wr, 0);
        chk({tag, "_last"}, out_chunk_last, 0);
        chk({tag, "_done"}, vec_done, 0);
        chk({tag, "_addr"}, wb_addr, 0);
        chk({tag, "_count"}, vec_count, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err_credit, 0);
    endtask

    task automatic apply_reset();
        rst_in = 1'b1;
        #1;
        check_reset_outputs("rst");
        model_reset();
        in_fifo_empty = 1'b1;
        layer_en = 1'b0;
        out_credit_return = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        #2 rst_in = 1'b0;
    endtask

    initial begin
        model_reset();
        layer_en = 1'b1;
        in_fifo_empty = 1'b0;
        apply_reset();

        // single vector: one-cycle enable, no returns
        step(1'b1, 1'b0, 4);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 0);
        chk("single_credits", m_cred, 0);
        refill();

        // back-to-back vectors with returns keeping credits topped up
        step(1'b1, 1'b0, 8);
        for (int i = 0; i < 10; i++) step(1'b1, (m_cred < OC), 0);
        for (int i = 0; i < 6; i++) step(1'b0, (m_cred < OC), 0);
        refill();

        // credit stall, return releases one more pop, then return+issue together
        step(1'b1, 1'b0, 6);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 0);
        step(1'b0, 1'b1, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0);
        refill();
        for (int i = 0; i < 8; i++) step(1'b0, (m_cred < OC), 2 * int'(i == 0));
        refill();

        // input starvation mid-vector with enable dropped after the first chunk
        step(1'b1, 1'b0, 2);
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 2);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 0);
        refill();

        // randomized traffic
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 3) != 0), (m_cred < OC) && ($urandom_range(0, 1) == 1),
                 ((avail < 6) && ($urandom_range(0, 2) == 0)) ? 1 : 0);
        for (int i = 0; i < 30; i++) step(1'b0, (m_cred < OC), 0);

        // asynchronous reset mid-vector, between edges, with writes pending
        step(1'b1, 1'b0, 4);
        step(1'b0, 1'b0, 0);
        #2;
        apply_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 4);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 0);
        refill();

        // spurious return at full credits, then a normal vector
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 4);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 0);
        refill();

        step(1'b0, 1'b0, 0);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
